// File: rtl/cu_sequencer_if.sv
// Control-unit sequencer bus: counter controls, opcode and ALU flags in, state and condition out.
// Optional instr_count signal exists only when CU_SEQ_INSTR_COUNT_EN is defined.
interface cu_sequencer_if #(
    parameter int STATES = 40,
    parameter int OPW    = 5
);
    logic              COUNTER_CLR;
    logic              COUNTER_LD;
    logic              COUNTER_INC;
    logic [OPW-1:0]    opcode;
    logic [3:0]        alu_nzcv;
    logic              flag_load;
    logic [STATES-1:0] CPU_state;
    logic [5:0]        state_idx;
    logic [3:0]        flags;
    logic              cond_pass;
    logic              illegal_op;
`ifdef CU_SEQ_INSTR_COUNT_EN
    logic [15:0]       instr_count;
`endif

    modport master (
        output COUNTER_CLR, COUNTER_LD, COUNTER_INC, opcode, alu_nzcv, flag_load,
`ifdef CU_SEQ_INSTR_COUNT_EN
        input  instr_count,
`endif
        input  CPU_state, state_idx, flags, cond_pass, illegal_op
    );

    modport slave (
        input  COUNTER_CLR, COUNTER_LD, COUNTER_INC, opcode, alu_nzcv, flag_load,
`ifdef CU_SEQ_INSTR_COUNT_EN
        output instr_count,
`endif
        output CPU_state, state_idx, flags, cond_pass, illegal_op
    );
endinterface

// File: rtl/cu_sequencer.sv
// Microcode state counter with one-hot decode, NZCV flag register and branch-condition evaluation.
// Latency: one clock from counter controls to state; no backpressure. Macro CU_SEQ_INSTR_COUNT_EN adds instr_count.
// Control priority CLR > LD > INC; state holds when none is asserted.
module cu_sequencer #(
    parameter int STATES = 40,
    parameter int OPW    = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    cu_sequencer_if.slave bus
);
    logic [5:0]  state_idx;
    logic [3:0]  flags;
    logic        illegal_op;
    logic [5:0]  ld_idx;
    logic        ld_bad;
    logic [31:0] op_ext;

    assign op_ext = 32'(bus.opcode);

    // Opcode to routine start state; unmapped opcodes fall back to fetch1.
    always_comb begin
        ld_idx = 6'd0;
        ld_bad = 1'b0;
        case (op_ext)
            32'd0:   ld_idx = 6'd3;
            32'd1:   ld_idx = 6'd4;
            32'd2:   ld_idx = 6'd5;
            32'd3:   ld_idx = 6'd7;
            32'd4:   ld_idx = 6'd9;
            32'd5:   ld_idx = 6'd13;
            32'd6:   ld_idx = 6'd17;
            32'd7:   ld_idx = 6'd21;
            32'd8:   ld_idx = 6'd22;
            32'd9:   ld_idx = 6'd23;
            32'd10:  ld_idx = 6'd24;
            32'd11:  ld_idx = 6'd25;
            32'd12:  ld_idx = 6'd26;
            32'd13:  ld_idx = 6'd28;
            32'd14:  ld_idx = 6'd30;
            32'd15:  ld_idx = 6'd32;
            32'd16:  ld_idx = 6'd34;
            32'd17:  ld_idx = 6'd36;
            32'd18:  ld_idx = 6'd38;
            default: ld_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_idx  <= 6'd0;
            illegal_op <= 1'b0;
        end else if (bus.COUNTER_CLR) begin
            state_idx <= 6'd0;
        end else if (bus.COUNTER_LD) begin
            state_idx <= ld_idx;
            if (ld_bad) begin
                illegal_op <= 1'b1;
            end
        end else if (bus.COUNTER_INC) begin
            state_idx <= (state_idx == 6'(STATES - 1)) ? 6'd0 : state_idx + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'd0;
        end else if (bus.flag_load) begin
            flags <= bus.alu_nzcv;
        end
    end

`ifdef CU_SEQ_INSTR_COUNT_EN
    logic [15:0] instr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= 16'd0;
        end else if (bus.COUNTER_LD && !bus.COUNTER_CLR) begin
            instr_count <= instr_count + 16'd1;
        end
    end

    assign bus.instr_count = instr_count;
`endif

    // Condition uses registered flags only, so a same-cycle flag_load affects the next cycle.
    always_comb begin
        bus.cond_pass = 1'b0;
        case (state_idx)
            6'd22:   bus.cond_pass = 1'b1;
            6'd23:   bus.cond_pass = !flags[2] && (flags[3] == flags[0]);
            6'd24:   bus.cond_pass = (flags[3] != flags[0]);
            6'd25:   bus.cond_pass = flags[2];
            default: bus.cond_pass = 1'b0;
        endcase
    end

    assign bus.CPU_state  = {{(STATES-1){1'b0}}, 1'b1} << state_idx;
    assign bus.state_idx  = state_idx;
    assign bus.flags      = flags;
    assign bus.illegal_op = illegal_op;
endmodule

// File: tb/tb_cu_sequencer.sv
// Randomized and directed checks of cu_sequencer against an integer-level reference model.
module tb_cu_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cu_sequencer_if #(.STATES(40), .OPW(5)) bus ();
    cu_sequencer #(.STATES(40), .OPW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    int       m_state;
    logic [3:0] m_flags;
    bit       m_illegal;
    int       m_count;
    int       start_map [19] = '{3, 4, 5, 7, 9, 13, 17, 21, 22, 23, 24, 25, 26, 28, 30, 32, 34, 36, 38};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_cond();
        case (m_state)
            22:      return 1'b1;
            23:      return !m_flags[2] && (m_flags[3] == m_flags[0]);
            24:      return m_flags[3] != m_flags[0];
            25:      return m_flags[2];
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".idx"},   64'(bus.state_idx),  64'(m_state));
        check({tag, ".onehot"}, 64'(bus.CPU_state), 64'd1 << m_state);
        check({tag, ".flags"}, 64'(bus.flags),      64'(m_flags));
        check({tag, ".cond"},  64'(bus.cond_pass),  64'(m_cond()));
        check({tag, ".ill"},   64'(bus.illegal_op), 64'(m_illegal));
`ifdef CU_SEQ_INSTR_COUNT_EN
        check({tag, ".cnt"},   64'(bus.instr_count), 64'(m_count));
`endif
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_flags   = 4'd0;
        m_illegal = 1'b0;
        m_count   = 0;
    endtask

    task automatic idle_inputs();
        bus.COUNTER_CLR = 1'b0;
        bus.COUNTER_LD  = 1'b0;
        bus.COUNTER_INC = 1'b0;
        bus.flag_load   = 1'b0;
        bus.opcode      = 5'd0;
        bus.alu_nzcv    = 4'd0;
    endtask

    task automatic step(input string tag, input bit clr, input bit ld, input bit inc,
                        input logic [4:0] op, input logic [3:0] nzcv, input bit fl);
        bus.COUNTER_CLR = clr;
        bus.COUNTER_LD  = ld;
        bus.COUNTER_INC = inc;
        bus.opcode      = op;
        bus.alu_nzcv    = nzcv;
        bus.flag_load   = fl;
        @(posedge clk);
        if (fl) m_flags = nzcv;
        if (clr) begin
            m_state = 0;
        end else if (ld) begin
            if (int'(op) < 19) begin
                m_state = start_map[op];
            end else begin
                m_state   = 0;
                m_illegal = 1'b1;
            end
        end else if (inc) begin
            m_state = (m_state + 1) % 40;
        end
        if (ld && !clr) m_count = (m_count + 1) % 65536;
        #1;
        check_all(tag);
    endtask

    // Asserted just after an edge; outputs must clear before any further edge.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("flagset", 0, 0, 0, 5'd0, 4'b1111, 1);
        step("ld_add",  0, 1, 0, 5'd12, 4'd0, 0);
        step("inc27",   0, 0, 1, 5'd0, 4'd0, 0);
        step("ld_bad0", 0, 1, 0, 5'd20, 4'd0, 0);
        step("ld_add2", 0, 1, 0, 5'd12, 4'd0, 0);
        step("inc27b",  0, 0, 1, 5'd0, 4'd0, 0);
        async_reset("mid27");
        step("postrst", 0, 0, 0, 5'd0, 4'd0, 0);
        step("ld_add3", 0, 1, 0, 5'd12, 4'd0, 0);
        step("inc27c",  0, 0, 1, 5'd0, 4'd0, 0);
        step("clr",     1, 0, 0, 5'd0, 4'd0, 0);

        step("prio3",   1, 1, 1, 5'd5, 4'd0, 0);
        step("prio2",   0, 1, 1, 5'd5, 4'd0, 0);
        step("hold",    0, 0, 0, 5'd5, 4'd0, 0);

        step("ld_mvn",  0, 1, 0, 5'd18, 4'd0, 0);
        step("inc39",   0, 0, 1, 5'd0, 4'd0, 0);
        step("wrap",    0, 0, 1, 5'd0, 4'd0, 0);
        step("ill25",   0, 1, 0, 5'd25, 4'd0, 0);
        step("ld_ldr",  0, 1, 0, 5'd3, 4'd0, 0);
        step("ld_b",    0, 1, 0, 5'd8, 4'd0, 0);

        step("fl1001",  0, 0, 0, 5'd0, 4'b1001, 1);
        step("bgt",     0, 1, 0, 5'd9, 4'd0, 0);
        step("fl0100",  0, 0, 0, 5'd0, 4'b0100, 1);
        step("beq",     0, 1, 0, 5'd11, 4'd0, 0);
        // Flag load in a branch state: condition still reflects the old flags this cycle.
        bus.flag_load = 1'b1;
        bus.alu_nzcv  = 4'b0000;
        #1;
        check("oldflags.cond", 64'(bus.cond_pass), 64'd1);
        step("newflags", 0, 0, 0, 5'd0, 4'b0000, 1);
        step("fl0100b", 0, 0, 0, 5'd0, 4'b0100, 1);
        step("blt",     0, 1, 0, 5'd10, 4'd0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset("rnd");
            end else begin
                step("rnd", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)),
                     4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
            end
        end

`ifdef CU_SEQ_INSTR_COUNT_EN
        async_reset("cnt");
        bus.opcode     = 5'd0;
        bus.COUNTER_LD = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        m_state = 3;
        m_count = 65535;
        check_all("cnt_ffff");
        step("cnt_wrap", 0, 1, 0, 5'd1, 4'd0, 0);
        step("cnt_clr",  1, 1, 0, 5'd1, 4'd0, 0);
`endif

        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cu_sequencer.md
CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 SHALL have parameter STATES, default 40, meaning the number of one-hot control states.
REQ-002 SHALL have parameter OPW, default 5, meaning the opcode width.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port COUNTER_CLR  input  1  return to fetch1 (state 0).
REQ-006 SHALL have port COUNTER_LD  input  1  load the routine start state selected by opcode.
REQ-007 SHALL have port COUNTER_INC  input  1  advance to the next state.
REQ-008 SHALL have port opcode  input  OPW  instruction opcode field from IR.
REQ-009 SHALL have port alu_nzcv  input  4  ALU flags {N,Z,C,V}.
REQ-010 SHALL have port flag_load  input  1  capture alu_nzcv into the flag register.
REQ-011 SHALL have port CPU_state  output  STATES  one-hot current state, bit i = state index i.
REQ-012 SHALL have port state_idx  output  6  binary current state index.
REQ-013 SHALL have port flags  output  4  registered {N,Z,C,V}.
REQ-014 SHALL have port cond_pass  output  1  branch condition true for the current state.
REQ-015 SHALL have port illegal_op  output  1  sticky flag: an unmapped opcode was loaded.

Function
REQ-016 SHALL hold a 6-bit state index register; CPU_state SHALL equal 1 shifted left by state_idx, and SHALL be exactly one-hot at all times.
REQ-017 SHALL apply control priority COUNTER_CLR > COUNTER_LD > COUNTER_INC; with none asserted, the state SHALL hold.
REQ-018 SHALL make COUNTER_CLR set state_idx to 0 on the next edge.
REQ-019 SHALL make COUNTER_INC set state_idx to state_idx+1, wrapping from STATES-1 to 0.
REQ-020 SHALL make COUNTER_LD load the start index as mapped: 0 nop->3, 1 mov->4, 2 ALTmov->5, 3 ldr->7, 4 ALTldr->9, 5 str->13, 6 ALTstr->17, 7 cmp->21, 8 b->22, 9 bgt->23, 10 blt->24, 11 beq->25, 12 add->26, 13 sub->28, 14 mul->30, 15 lsr->32, 16 and->34, 17 or->36, 18 mvn->38.
REQ-021 SHALL make COUNTER_LD with an opcode of 19..31 load state 0 and set illegal_op, which stays at 1 until reset.
REQ-022 SHALL capture alu_nzcv into flags on the edge on which flag_load=1, and hold flags otherwise; flag_load is independent of the counter controls.
REQ-023 SHALL drive cond_pass combinationally from the registered flags and state_idx: state 22 (b) ->1; state 23 (bgt) ->Z=0 and N=V; state 24 (blt) ->N!=V; state 25 (beq) ->Z=1; all other states ->0.
REQ-024 SHALL base cond_pass on the old flags when flag_load and a branch state coincide; the new flags apply from the next cycle.
REQ-025 SHALL have a latency of one clock from the control input to the CPU_state update; no output SHALL have a combinational path from the counter controls.

Reset
REQ-026 SHALL, while rst_n=0 (asynchronously), set state_idx=0, CPU_state=1 (fetch1), flags=0, cond_pass=0, illegal_op=0 and instr_count=0.
REQ-027 SHALL discard any in-progress routine on a reset mid-routine; after release, sequencing SHALL start at fetch1 on the first edge with rst_n=1.

Configuration
REQ-028 SHALL compile in, when the macro CU_SEQ_INSTR_COUNT_EN is defined, the output port instr_count (output, 16 bits), which increments by 1 on every accepted COUNTER_LD (illegal opcodes included), wraps at 0xFFFF->0, and does not increment when COUNTER_CLR is asserted in the same cycle.
REQ-029 SHALL omit the port and counter entirely when CU_SEQ_INSTR_COUNT_EN is undefined; all other behaviour SHALL be identical.

Verification
REQ-030 SHALL cover: reset asserted while state=27 -> CPU_state=40'h1 immediately; illegal_op=0 and flags=0 after release.
REQ-031 SHALL cover: COUNTER_LD with opcode=12 -> state_idx=26; COUNTER_INC -> 27; COUNTER_CLR -> 0, CPU_state=40'h1.
REQ-032 SHALL cover: COUNTER_CLR, COUNTER_LD and COUNTER_INC all asserted together with opcode=5 -> state_idx=0; COUNTER_LD and COUNTER_INC together -> state_idx=13.
REQ-033 SHALL cover: state 39 with COUNTER_INC -> state_idx=0; COUNTER_LD with opcode=25 -> state_idx=0 and illegal_op=1, which persists through later valid loads.
REQ-034 SHALL cover: flag_load with alu_nzcv=4'b1001, then COUNTER_LD with opcode=9 -> cond_pass=1 in state 23; alu_nzcv=4'b0100 with opcode=11 -> cond_pass=1 in state 25 and 0 in state 24.
REQ-035 SHALL cover, with CU_SEQ_INSTR_COUNT_EN defined: instr_count preset to 0xFFFF via 65535 loads, one more COUNTER_LD -> instr_count=0; COUNTER_LD together with COUNTER_CLR -> no increment.
